// File: rtl/zone_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// zone_scan_ctrl_pkg
//   Shared definitions for the zone scan controller:
//     - state_e      : scan FSM states
//     - W1/W2/W3     : left-shift weights applied for judge1/judge2/judge3 hits
//     - ACC_W/PIX_W  : accumulator and pixel widths
//     - LED_W/POS_W  : LED level and row/column position widths
//     - sat_add()    : unsigned add that sticks at all-ones instead of wrapping
// -----------------------------------------------------------------------------
package zone_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_ACC  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int W1 = 2;
    localparam int W2 = 1;
    localparam int W3 = 0;

    localparam int ACC_W = 16;
    localparam int PIX_W = 8;
    localparam int LED_W = 8;
    localparam int POS_W = 7;

    // The carry-out of the widened sum tells us the true result no longer fits.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/zone_acc.sv
// -----------------------------------------------------------------------------
// zone_acc
//   Weighted, saturating luma accumulator used by zone_scan_ctrl.
//   A pixel and its three zone flags are captured together, then a later
//   accumulate strobe adds the weighted pixel into a 16-bit saturating sum.
//
// Ports
//   clk_i          clock (rising edge)
//   rst_i          synchronous active-high reset, clears the accumulator
//   clr_i          clear the accumulator (start of a scan)
//   cap_i          capture pix_i and the judge flags
//   acc_en_i       add the weighted captured pixel into the accumulator
//   pix_i          block luma
//   j1_i/j2_i/j3_i zone flags; j1 has the highest priority
//   level_next_o   LED level derived from the accumulator value that will be
//                  registered on this edge: min(acc >> OUT_SHIFT, 255)
// -----------------------------------------------------------------------------
module zone_acc
    import zone_scan_ctrl_pkg::*;
#(
    parameter int OUT_SHIFT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             cap_i,
    input  logic             acc_en_i,
    input  logic [PIX_W-1:0] pix_i,
    input  logic             j1_i,
    input  logic             j2_i,
    input  logic             j3_i,
    output logic [LED_W-1:0] level_next_o
);

    logic [PIX_W-1:0] pix_q;
    logic [2:0]       jdg_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] pix_ext;
    logic [ACC_W-1:0] contrib;
    logic [ACC_W-1:0] shifted;

    // Capture registers hold pure data and need no reset.
    always_ff @(posedge clk_i) begin
        if (cap_i) begin
            pix_q <= pix_i;
            jdg_q <= {j3_i, j2_i, j1_i};
        end
    end

    always_comb begin
        pix_ext = {{(ACC_W-PIX_W){1'b0}}, pix_q};
        contrib = '0;
        if (jdg_q[0]) begin
            contrib = pix_ext << W1;
        end else if (jdg_q[1]) begin
            contrib = pix_ext << W2;
        end else if (jdg_q[2]) begin
            contrib = pix_ext << W3;
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = sat_add(acc_q, contrib);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Level is taken from acc_d so the controller can load the LED register
    // on the same edge that the final contribution lands.
    always_comb begin
        shifted = acc_d >> OUT_SHIFT;
        if (|shifted[ACC_W-1:LED_W]) begin
            level_next_o = {LED_W{1'b1}};
        end else begin
            level_next_o = shifted[LED_W-1:0];
        end
    end

endmodule

// File: rtl/zone_scan_ctrl.sv
// -----------------------------------------------------------------------------
// zone_scan_ctrl
//   Scans a ROWS x SCAN_COLS grid of blocks. For each cell it requests the
//   block luma, waits (without timeout) for it, weights it by the external
//   zone judges and accumulates it. After the last cell the LED level is
//   updated from the accumulator and done pulses for one cycle.
//
// Ports
//   clk                 clock (rising edge)
//   rst                 synchronous active-high reset
//   start               one-cycle pulse; accepted only when idle
//   row_now/col_now     current cell, 1-based, driven to the area judges
//   judge1..judge3      combinational zone flags for row_now/col_now
//   pix_req             one-cycle request for the luma of the current cell
//   pix_valid/pix_data  luma response; only honoured while waiting
//   busy                high in every non-idle state
//   done                one-cycle pulse when led_level has been updated
//   led_level           LED drive level, held between scans
// -----------------------------------------------------------------------------
module zone_scan_ctrl
    import zone_scan_ctrl_pkg::*;
#(
    parameter int ROWS      = 24,
    parameter int SCAN_COLS = 3,
    parameter int OUT_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [POS_W-1:0] row_now,
    output logic [POS_W-1:0] col_now,
    input  logic             judge1,
    input  logic             judge2,
    input  logic             judge3,
    output logic             pix_req,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             busy,
    output logic             done,
    output logic [LED_W-1:0] led_level
);

    localparam logic [POS_W-1:0] LAST_ROW = POS_W'(ROWS);
    localparam logic [POS_W-1:0] LAST_COL = POS_W'(SCAN_COLS);

    state_e           state_q, state_d;
    logic [POS_W-1:0] row_q, row_d;
    logic [POS_W-1:0] col_q, col_d;
    logic [LED_W-1:0] led_q, led_d;

    logic             acc_clr;
    logic             acc_cap;
    logic             acc_en;
    logic [LED_W-1:0] level_next;

    zone_acc #(
        .OUT_SHIFT (OUT_SHIFT)
    ) u_acc (
        .clk_i        (clk),
        .rst_i        (rst),
        .clr_i        (acc_clr),
        .cap_i        (acc_cap),
        .acc_en_i     (acc_en),
        .pix_i        (pix_data),
        .j1_i         (judge1),
        .j2_i         (judge2),
        .j3_i         (judge3),
        .level_next_o (level_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        led_d   = led_q;
        acc_clr = 1'b0;
        acc_cap = 1'b0;
        acc_en  = 1'b0;
        pix_req = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    acc_clr = 1'b1;
                    row_d   = POS_W'(1);
                    col_d   = POS_W'(1);
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                pix_req = 1'b1;
                state_d = ST_WAIT;
            end

            // Judges are sampled with the pixel so both describe the same cell.
            ST_WAIT: begin
                if (pix_valid) begin
                    acc_cap = 1'b1;
                    state_d = ST_ACC;
                end
            end

            ST_ACC: begin
                acc_en = 1'b1;
                if (col_q < LAST_COL) begin
                    col_d   = col_q + POS_W'(1);
                    state_d = ST_REQ;
                end else if (row_q < LAST_ROW) begin
                    col_d   = POS_W'(1);
                    row_d   = row_q + POS_W'(1);
                    state_d = ST_REQ;
                end else begin
                    // Last cell: the LED register picks up the final sum now,
                    // so led_level is already new while done is high.
                    led_d   = level_next;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign row_now   = row_q;
    assign col_now   = col_q;
    assign led_level = led_q;

endmodule

// File: tb/tb_zone_scan_ctrl.sv
module tb_zone_scan_ctrl;

    localparam int ROWS  = 24;
    localparam int COLS  = 3;
    localparam int SHIFT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] row_now;
    logic [6:0] col_now;
    logic       judge1, judge2, judge3;
    logic       pix_req;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       busy;
    logic       done;
    logic [7:0] led_level;

    zone_scan_ctrl #(
        .ROWS      (ROWS),
        .SCAN_COLS (COLS),
        .OUT_SHIFT (SHIFT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .row_now   (row_now),
        .col_now   (col_now),
        .judge1    (judge1),
        .judge2    (judge2),
        .judge3    (judge3),
        .pix_req   (pix_req),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .busy      (busy),
        .done      (done),
        .led_level (led_level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // scenario knobs
    int cur_id    = 5;
    int cur_mode  = 0;   // 0: window around row cur_id, 1: judge1 everywhere
    int cur_pix   = 100; // <0 selects a per-cell pattern
    int max_delay = 0;
    bit glitch_en = 0;

    // behavioural expectations
    int exp_led  = 0;
    int held_led = 0;
    bit in_scan  = 0;
    int done_cnt = 0;
    bit saw_wrap = 0;

    logic [6:0] rsp_r, rsp_c;
    int         rsp_dly;

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Zone judges: a small window of rows around the zone ID, wrapping at 128.
    function automatic logic jf(input int which, input logic [6:0] r, input logic [6:0] c,
                                input int id, input int mode);
        logic [6:0] diff;
        int d;
        diff = r - 7'(id);
        d = (diff >= 7'd64) ? int'(diff) - 128 : int'(diff);
        if (mode == 1) return (which == 1);
        case (which)
            1:       return (d == 0 || d == 1) && c == 7'd2;
            2:       return (d == 0 || d == -1);
            default: return (d == -2 && c == 7'd2) || ((d == 0 || d == 1) && c == 7'd2);
        endcase
    endfunction

    assign judge1 = jf(1, row_now, col_now, cur_id, cur_mode);
    assign judge2 = jf(2, row_now, col_now, cur_id, cur_mode);
    assign judge3 = jf(3, row_now, col_now, cur_id, cur_mode);

    function automatic int pixf(input int r, input int c, input int sel);
        return (sel >= 0) ? sel : ((r * 37 + c * 11 + 5) % 256);
    endfunction

    function automatic int weight(input int r, input int c, input int id, input int mode);
        if (jf(1, 7'(r), 7'(c), id, mode)) return 4;
        if (jf(2, 7'(r), 7'(c), id, mode)) return 2;
        if (jf(3, 7'(r), 7'(c), id, mode)) return 1;
        return 0;
    endfunction

    function automatic int model_acc(input int id, input int mode, input int sel);
        int a = 0;
        for (int r = 1; r <= ROWS; r++)
            for (int c = 1; c <= COLS; c++) begin
                a += pixf(r, c, sel) * weight(r, c, id, mode);
                if (a > 65535) a = 65535;
            end
        return a;
    endfunction

    function automatic int model_led(input int a);
        int s;
        s = a >> SHIFT;
        return (s > 255) ? 255 : s;
    endfunction

    // Pixel source: answers every request, optionally late, and optionally
    // throws stray pix_valid pulses at states where they must be ignored.
    initial begin
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        forever begin
            @(negedge clk);
            pix_valid = 1'b0;
            if (pix_req && !rst) begin
                rsp_r = row_now;
                rsp_c = col_now;
                if (rsp_r < 7'd1 || rsp_r > 7'(ROWS)) saw_wrap = 1'b1;
                check("req_row_range", int'(rsp_r >= 7'd1 && rsp_r <= 7'(ROWS)), 1);
                if (glitch_en && $urandom_range(0, 1) == 1) begin
                    pix_valid = 1'b1;
                    pix_data  = 8'hFF;
                end
                @(negedge clk);
                pix_valid = 1'b0;
                rsp_dly = (max_delay > 0) ? int'($urandom_range(0, max_delay)) : 0;
                repeat (rsp_dly) @(negedge clk);
                if (busy) check("cell_stable", int'(row_now == rsp_r && col_now == rsp_c), 1);
                pix_valid = 1'b1;
                pix_data  = 8'(pixf(int'(rsp_r), int'(rsp_c), cur_pix));
                @(negedge clk);
                pix_valid = 1'b0;
                if (glitch_en && $urandom_range(0, 1) == 1) begin
                    pix_valid = 1'b1;
                    pix_data  = 8'hFF;
                end
            end else if (glitch_en && $urandom_range(0, 3) == 0) begin
                pix_valid = 1'b1;
                pix_data  = 8'hFF;
            end
        end
    end

    // Per-cycle comparison of busy/done/led_level against the scan model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("busy", int'(busy), int'(in_scan));
                if (done) begin
                    done_cnt++;
                    check("done_expected", int'(in_scan), 1);
                    check("led_at_done", int'(led_level), exp_led);
                    held_led = exp_led;
                    in_scan  = 1'b0;
                end else begin
                    check("led_held", int'(led_level), held_led);
                end
            end
        end
    end

    task automatic run_scan(input int id, input int mode, input int sel, input int dly,
                            input bit glitch, input int restart_at, output int led_got);
        int cyc;
        cur_id    = id;
        cur_mode  = mode;
        cur_pix   = sel;
        max_delay = dly;
        glitch_en = glitch;
        exp_led   = model_led(model_acc(id, mode, sel));
        done_cnt  = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        in_scan = 1'b1;
        cyc = 0;
        while (in_scan && cyc < 3000) begin
            start = (restart_at > 0 && cyc == restart_at);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("scan_timeout", int'(in_scan), 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_count", done_cnt, 1);
        led_got = int'(led_level);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int led_a, led_b, cyc;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;            // coincident with reset: reset wins
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_row",     int'(row_now),   0);
        check("rst_col",     int'(col_now),   0);
        check("rst_pix_req", int'(pix_req),   0);
        check("rst_busy",    int'(busy),      0);
        check("rst_done",    int'(done),      0);
        check("rst_led",     int'(led_level), 0);

        // model pinned against hand-computed sums
        check("model_id5_100", model_acc(5, 0, 100), 1900);
        check("model_id5_255", model_acc(5, 0, 255), 4845);
        check("model_id1_100", model_acc(1, 0, 100), 1200);
        check("model_sat_228", model_acc(1, 1, 228), 65535);

        run_scan(5, 0, 100, 0, 0, 0, led_a);
        check("led_id5_100", led_a, 118);
        run_scan(5, 0, 255, 0, 0, 0, led_a);
        check("led_id5_255_clamp", led_a, 255);
        saw_wrap = 1'b0;
        run_scan(1, 0, 100, 0, 0, 0, led_a);
        check("led_id1_100", led_a, 75);
        check("wrap_rows_scanned", int'(saw_wrap), 0);

        run_scan(5, 0, -1, 0, 0, 0, led_a);
        run_scan(5, 0, -1, 5, 1, 0, led_b);
        check("delay_equiv", led_b, led_a);

        run_scan(1, 1, 228, 0, 0, 0, led_a);
        check("led_saturated", led_a, 255);

        // abort mid-scan at row 10
        cur_id = 5; cur_mode = 0; cur_pix = 100; max_delay = 2; glitch_en = 0;
        exp_led  = model_led(model_acc(5, 0, 100));
        done_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        in_scan = 1'b1;
        cyc = 0;
        while (row_now != 7'd10 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reach_row10", int'(row_now), 10);
        rst      = 1'b1;
        in_scan  = 1'b0;
        held_led = 0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        check("abort_led_zero", int'(led_level), 0);
        run_scan(5, 0, 100, 0, 0, 0, led_a);
        check("led_after_abort", led_a, 118);

        // start pulsed in the middle of a scan
        run_scan(7, 0, -1, 1, 0, 25, led_a);
        check("led_restart_ignored", led_a, model_led(model_acc(7, 0, -1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
